// File: rtl/patch_remap_override.sv
// Programmable control-bus remap with triggered, time-limited masked overrides.
// Configuration streams serially into a shadow register and is committed only while idle.
module patch_remap_override #(
   parameter int W      = 38,
   parameter int M      = 4,
   parameter int IDXW   = 6,
   parameter int HOLD_W = 8,
   localparam int CFG_BITS = W*IDXW + M*(2*W + HOLD_W),
   localparam int AW       = (M > 1) ? $clog2(M) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bitstreamSerialIn,
   input  logic          bitstreamValid,
   input  logic          cfgCommit,
   input  logic [M-1:0]  trigger,
   input  logic [W-1:0]  qIn,
   output logic [W-1:0]  qOut,
   output logic          overrideActive,
   output logic [AW-1:0] activeIdx,
   output logic          cfgApplied
);

   typedef enum logic [0:0] {sIdle, sHold} stateT;

   localparam logic [IDXW:0] selLimit = (IDXW+1)'(W);

   logic [CFG_BITS-1:0] shadow;
   logic                commitPending;
   logic [IDXW-1:0]     sel   [W];
   logic [W-1:0]        mask  [M];
   logic [W-1:0]        value [M];
   logic [HOLD_W-1:0]   hold  [M];

   stateT             state, stateNext;
   logic [HOLD_W-1:0] cnt, cntNext;
   logic [AW-1:0]     idxNext;
   logic              ovrNext;

   logic          anyQual;
   logic [AW-1:0] firstIdx;
   logic          doCommit;

   logic [W-1:0] selValid;
   logic [W-1:0] qInt;
   logic [W-1:0] qOvr;

   // Lowest-index trigger whose record is enabled (non-zero hold)
   always_comb begin
      anyQual  = 1'b0;
      firstIdx = '0;
      for (int k = M-1; k >= 0; k--) begin
         if (trigger[k] && (hold[k] != '0)) begin
            anyQual  = 1'b1;
            firstIdx = AW'(k);
         end
      end
   end

   assign doCommit = commitPending && (state == sIdle) && !bitstreamValid && !anyQual;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      idxNext   = activeIdx;
      ovrNext   = overrideActive;
      case (state)
         sIdle: begin
            if (anyQual) begin
               stateNext = sHold;
               cntNext   = hold[firstIdx];
               idxNext   = firstIdx;
               ovrNext   = 1'b1;
            end
         end
         sHold: begin
            // Preempt/extend wins over the exit on the final cycle
            if (anyQual && (firstIdx <= activeIdx)) begin
               cntNext = hold[firstIdx];
               idxNext = firstIdx;
            end else if (cnt == HOLD_W'(1)) begin
               stateNext = sIdle;
               cntNext   = '0;
               idxNext   = '0;
               ovrNext   = 1'b0;
            end else begin
               cntNext = cnt - HOLD_W'(1);
            end
         end
         default: begin
            stateNext = sIdle;
            cntNext   = '0;
            idxNext   = '0;
            ovrNext   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= sIdle;
         cnt            <= '0;
         activeIdx      <= '0;
         overrideActive <= 1'b0;
      end else begin
         state          <= stateNext;
         cnt            <= cntNext;
         activeIdx      <= idxNext;
         overrideActive <= ovrNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow        <= '0;
         commitPending <= 1'b0;
         cfgApplied    <= 1'b0;
         for (int i = 0; i < W; i++) sel[i] <= IDXW'(i);
         for (int k = 0; k < M; k++) begin
            mask[k]  <= '0;
            value[k] <= '0;
            hold[k]  <= '0;
         end
      end else begin
         cfgApplied <= doCommit;
         if (bitstreamValid) shadow <= {shadow[CFG_BITS-2:0], bitstreamSerialIn};
         if (doCommit)       commitPending <= 1'b0;
         else if (cfgCommit) commitPending <= 1'b1;
         if (doCommit) begin
            for (int i = 0; i < W; i++) sel[i] <= shadow[i*IDXW +: IDXW];
            for (int k = 0; k < M; k++) begin
               mask[k]  <= shadow[W*IDXW + k*(2*W+HOLD_W)       +: W];
               value[k] <= shadow[W*IDXW + k*(2*W+HOLD_W) + W   +: W];
               hold[k]  <= shadow[W*IDXW + k*(2*W+HOLD_W) + 2*W +: HOLD_W];
            end
         end
      end
   end

   // Forward permutation; out-of-range sources read as zero
   always_comb begin
      selValid = '0;
      qInt     = '0;
      for (int i = 0; i < W; i++) begin
         selValid[i] = ({1'b0, sel[i]} < selLimit);
         qInt[i]     = selValid[i] ? qIn[sel[i]] : 1'b0;
      end
   end

   assign qOvr = overrideActive ? ((qInt & ~mask[activeIdx]) | (value[activeIdx] & mask[activeIdx]))
                                : qInt;

   // Inverse permutation: descending loop so the lowest source index wins
   always_comb begin
      qOut = qIn;
      for (int i = W-1; i >= 0; i--) begin
         if (selValid[i]) qOut[sel[i]] = qOvr[i];
      end
   end

endmodule

// File: tb/tb_patch_remap_override.sv
// Directed bench for patch_remap_override: remap, override priority, commit deferral, reset.
module tb_patch_remap_override;

   localparam int W        = 38;
   localparam int M        = 4;
   localparam int IDXW     = 6;
   localparam int HOLD_W   = 8;
   localparam int CFG_BITS = W*IDXW + M*(2*W + HOLD_W);

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         bitstreamSerialIn = 1'b0;
   logic         bitstreamValid = 1'b0;
   logic         cfgCommit = 1'b0;
   logic [M-1:0] trigger = '0;
   logic [W-1:0] qIn = '0;
   logic [W-1:0] qOut;
   logic         overrideActive;
   logic [1:0]   activeIdx;
   logic         cfgApplied;

   int totalCount = 0;
   int passCount  = 0;

   logic [IDXW-1:0]   tSel  [W];
   logic [W-1:0]      tMask [M];
   logic [W-1:0]      tVal  [M];
   logic [HOLD_W-1:0] tHold [M];
   logic              sawApplied;

   localparam logic [W-1:0] qPat = 38'h2A_5555_AAAA;
   localparam logic [W-1:0] e0   = 38'h2A_5555_C3AA;
   localparam logic [W-1:0] e2   = 38'h2A_5555_AA5A;
   localparam logic [W-1:0] e3   = 38'h15_5555_AAAA;
   localparam logic [W-1:0] e2c  = 38'h2A_5555_AA33;

   patch_remap_override dut (
      .clk               (clk),
      .rst               (rst),
      .bitstreamSerialIn (bitstreamSerialIn),
      .bitstreamValid    (bitstreamValid),
      .cfgCommit         (cfgCommit),
      .trigger           (trigger),
      .qIn               (qIn),
      .qOut              (qOut),
      .overrideActive    (overrideActive),
      .activeIdx         (activeIdx),
      .cfgApplied        (cfgApplied)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic setDefaultCfg();
      for (int i = 0; i < W; i++) tSel[i] = IDXW'(i);
      for (int k = 0; k < M; k++) begin
         tMask[k] = '0;
         tVal[k]  = '0;
         tHold[k] = '0;
      end
   endtask

   function automatic logic [CFG_BITS-1:0] packCfg();
      logic [CFG_BITS-1:0] c;
      int base;
      c = '0;
      for (int i = 0; i < W; i++) c[i*IDXW +: IDXW] = tSel[i];
      for (int k = 0; k < M; k++) begin
         base = W*IDXW + k*(2*W + HOLD_W);
         c[base +: W]            = tMask[k];
         c[base + W +: W]        = tVal[k];
         c[base + 2*W +: HOLD_W] = tHold[k];
      end
      return c;
   endfunction

   // MSB first, so bit 0 of the image is the last one shifted in
   task automatic shiftCfg(input bit commitAtStart, input int nBits);
      logic [CFG_BITS-1:0] c;
      c = packCfg();
      sawApplied = 1'b0;
      for (int n = 0; n < nBits; n++) begin
         bitstreamSerialIn = c[CFG_BITS-1-n];
         bitstreamValid    = 1'b1;
         cfgCommit         = commitAtStart && (n == 0);
         step();
         if (cfgApplied) sawApplied = 1'b1;
      end
      bitstreamValid    = 1'b0;
      bitstreamSerialIn = 1'b0;
      cfgCommit         = 1'b0;
   endtask

   initial begin
      // Reset state
      #2 rst = 1'b1;
      qIn = qPat;
      step();
      step();
      check("rst_qout", 64'(qOut), 64'(qPat));
      check("rst_ovr", 64'(overrideActive), 64'd0);
      check("rst_idx", 64'(activeIdx), 64'd0);
      check("rst_applied", 64'(cfgApplied), 64'd0);
      rst = 1'b0;
      step();

      // Config A: swap 0<->37, sel[5] invalid, record 0 forces qInt bit 0
      setDefaultCfg();
      tSel[0]  = 6'd37;
      tSel[37] = 6'd0;
      tSel[5]  = 6'd40;
      tMask[0] = 38'h1;
      tVal[0]  = 38'h1;
      tHold[0] = 8'd1;
      shiftCfg(1'b0, CFG_BITS);
      check("shiftA_noapply", 64'(sawApplied), 64'd0);
      trigger = 4'b0001;
      step();
      trigger = '0;
      check("precommit_no_ovr", 64'(overrideActive), 64'd0);
      cfgCommit = 1'b1;
      step();
      cfgCommit = 1'b0;
      check("commitA_pending", 64'(cfgApplied), 64'd0);
      step();
      check("commitA_pulse", 64'(cfgApplied), 64'd1);
      step();
      check("commitA_single", 64'(cfgApplied), 64'd0);
      qIn = 38'h1;
      #1;
      check("perm_roundtrip", 64'(qOut), 64'h1);
      qIn = 38'h20;
      #1;
      check("sel_invalid_pass", 64'(qOut), 64'h20);
      qIn = '0;
      trigger = 4'b0001;
      step();
      trigger = '0;
      check("permovr_active", 64'(overrideActive), 64'd1);
      check("permovr_qout", 64'(qOut), 64'(38'h20_0000_0000));
      step();
      check("permovr_exit", 64'(overrideActive), 64'd0);
      check("permovr_exit_qout", 64'(qOut), 64'd0);

      // Config B: identity, four records; commit requested while shifting
      setDefaultCfg();
      tMask[0] = 38'hFF00;          tVal[0] = 38'hC300;          tHold[0] = 8'd2;
      tMask[1] = 38'hFF;            tVal[1] = 38'hFF;            tHold[1] = 8'd0;
      tMask[2] = 38'hFF;            tVal[2] = 38'h5A;            tHold[2] = 8'd3;
      tMask[3] = 38'h3F_0000_0000;  tVal[3] = 38'h15_0000_0000;  tHold[3] = 8'd4;
      shiftCfg(1'b1, CFG_BITS);
      check("commit_deferred_shift", 64'(sawApplied), 64'd0);
      step();
      check("commitB_pulse", 64'(cfgApplied), 64'd1);
      step();
      check("commitB_single", 64'(cfgApplied), 64'd0);
      qIn = qPat;

      // Record 2, hold 3
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("r2_c1_ovr", 64'(overrideActive), 64'd1);
      check("r2_c1_idx", 64'(activeIdx), 64'd2);
      check("r2_c1_qout", 64'(qOut), 64'(e2));
      step();
      check("r2_c2_qout", 64'(qOut), 64'(e2));
      step();
      check("r2_c3_ovr", 64'(overrideActive), 64'd1);
      step();
      check("r2_end_ovr", 64'(overrideActive), 64'd0);
      check("r2_end_idx", 64'(activeIdx), 64'd0);
      check("r2_end_qout", 64'(qOut), 64'(qPat));

      // Preempt by record 0 at cnt=2
      trigger = 4'b0100;
      step();
      trigger = '0;
      step();
      trigger = 4'b0001;
      step();
      trigger = '0;
      check("preempt_idx", 64'(activeIdx), 64'd0);
      check("preempt_qout", 64'(qOut), 64'(e0));
      step();
      check("preempt_c2_ovr", 64'(overrideActive), 64'd1);
      step();
      check("preempt_end", 64'(overrideActive), 64'd0);

      // Lower-priority trigger ignored mid-hold
      trigger = 4'b0100;
      step();
      trigger = 4'b1000;
      step();
      trigger = '0;
      check("ignore_idx", 64'(activeIdx), 64'd2);
      check("ignore_qout", 64'(qOut), 64'(e2));
      step();
      check("ignore_c3_ovr", 64'(overrideActive), 64'd1);
      step();
      check("ignore_end", 64'(overrideActive), 64'd0);

      // Record 3 on its own, hold 4
      trigger = 4'b1000;
      step();
      trigger = '0;
      check("r3_idx", 64'(activeIdx), 64'd3);
      check("r3_qout", 64'(qOut), 64'(e3));
      step();
      step();
      step();
      check("r3_c4_ovr", 64'(overrideActive), 64'd1);
      step();
      check("r3_end", 64'(overrideActive), 64'd0);

      // Extend: re-trigger record 2 at cnt=1
      trigger = 4'b0100;
      step();
      trigger = '0;
      step();
      step();
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("extend_c1", 64'(overrideActive), 64'd1);
      step();
      check("extend_c2", 64'(overrideActive), 64'd1);
      step();
      check("extend_c3", 64'(overrideActive), 64'd1);
      step();
      check("extend_end", 64'(overrideActive), 64'd0);

      // Simultaneous triggers; record 1 is disabled so record 2 wins
      trigger = 4'b1110;
      step();
      trigger = '0;
      check("simul_idx", 64'(activeIdx), 64'd2);
      step();
      step();
      step();
      check("simul_end", 64'(overrideActive), 64'd0);

      // Disabled record alone
      trigger = 4'b0010;
      step();
      trigger = '0;
      check("disabled_ovr", 64'(overrideActive), 64'd0);
      check("disabled_qout", 64'(qOut), 64'(qPat));

      // Config C shifted but committed during a hold
      tVal[2]  = 38'h33;
      tHold[2] = 8'd2;
      shiftCfg(1'b0, CFG_BITS);
      check("shiftC_noapply", 64'(sawApplied), 64'd0);
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("oldcfg_qout", 64'(qOut), 64'(e2));
      cfgCommit = 1'b1;
      step();
      cfgCommit = 1'b0;
      check("hold_commit_c2", 64'(cfgApplied), 64'd0);
      step();
      check("hold_commit_c3", 64'(cfgApplied), 64'd0);
      step();
      check("hold_commit_idle_ovr", 64'(overrideActive), 64'd0);
      check("hold_commit_idle", 64'(cfgApplied), 64'd0);
      step();
      check("hold_commit_pulse", 64'(cfgApplied), 64'd1);
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("newcfg_qout", 64'(qOut), 64'(e2c));
      step();
      check("newcfg_c2", 64'(overrideActive), 64'd1);
      step();
      check("newcfg_end", 64'(overrideActive), 64'd0);

      // Reset mid-hold
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("prerst_ovr", 64'(overrideActive), 64'd1);
      rst = 1'b1;
      #1;
      check("rsthold_ovr", 64'(overrideActive), 64'd0);
      check("rsthold_idx", 64'(activeIdx), 64'd0);
      check("rsthold_qout", 64'(qOut), 64'(qPat));
      step();
      rst = 1'b0;
      trigger = 4'b0100;
      step();
      trigger = '0;
      check("postrst_recs_clear", 64'(overrideActive), 64'd0);

      // Reset mid-shift with a commit pending
      shiftCfg(1'b1, 100);
      rst = 1'b1;
      #1;
      check("rstshift_qout", 64'(qOut), 64'(qPat));
      check("rstshift_applied", 64'(cfgApplied), 64'd0);
      step();
      rst = 1'b0;
      step();
      check("pending_cleared_1", 64'(cfgApplied), 64'd0);
      step();
      check("pending_cleared_2", 64'(cfgApplied), 64'd0);
      cfgCommit = 1'b1;
      step();
      cfgCommit = 1'b0;
      step();
      check("zero_commit_pulse", 64'(cfgApplied), 64'd1);
      check("zero_cfg_qout", 64'(qOut), 64'(qPat));
      qIn = 38'h15_AAAA_5555;
      #1;
      check("zero_cfg_qout2", 64'(qOut), 64'(38'h15_AAAA_5555));
      trigger = 4'b1111;
      step();
      trigger = '0;
      check("zero_cfg_no_ovr", 64'(overrideActive), 64'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/patch_remap_override.md
Name: patch_remap_override

Overview:
- Parametrised successor to the fixed-wiring patch top.
- The control-vector bit permutation between the design and the remediation datapath is programmed through the serial bitstream rather than hard-wired.
- M trigger lines each select a masked override of the control vector, held for a programmable number of cycles.
- Sits between the monitored design's control bus and its consumers, fed by the monitoring unit's trigger vector.

Parameters:
- W, 38, control vector width (C+S).
- M, 4, number of trigger lines / override records.
- IDXW, 6, width of one permutation source index (>= clog2(W)).
- HOLD_W, 8, width of per-record hold length.
- CFG_BITS, W*IDXW + M*(2*W+HOLD_W), shadow shift-register length (derived; do not override).

Ports:
- clk  in  1  sole clock (configuration and datapath).
- rst  in  1  asynchronous, active-high reset.
- bitstreamSerialIn  in  1  serial configuration bit.
- bitstreamValid  in  1  shift enable for bitstreamSerialIn.
- cfgCommit  in  1  single-cycle request to copy shadow config to active config.
- trigger  in  M  trigger vector from the monitoring unit; bit 0 has highest priority.
- qIn  in  W  control vector from the design.
- qOut  out  W  remediated control vector.
- overrideActive  out  1  high while an override is applied (registered).
- activeIdx  out  clog2(M)  index of the applied record; 0 when idle.
- cfgApplied  out  1  one-cycle pulse in the cycle the active config updates.

Behaviour:
- Reset (async, rst=1):
  - shadow = 0; commitPending = 0; state IDLE; cnt = 0.
  - Active permutation is identity (sel[i]=i); all masks, values and hold lengths are 0.
  - overrideActive = 0, activeIdx = 0, cfgApplied = 0, so qOut = qIn.
- Shadow shift:
  - On each clk with bitstreamValid=1: shadow <= {shadow[CFG_BITS-2:0], bitstreamSerialIn}. The last bit shifted in is shadow[0].
  - Layout from LSB:
    - sel[i] = shadow[i*IDXW +: IDXW] for i=0..W-1.
    - Record k starts at base B = W*IDXW + k*(2W+HOLD_W): mask[k] = [B +: W], value[k] = [B+W +: W], hold[k] = [B+2W +: HOLD_W].
  - Shifting never alters the active config.
- Commit:
  - cfgCommit=1 sets commitPending.
  - The copy shadow->active happens on the first clk edge where commitPending=1, state=IDLE, bitstreamValid=0 and no trigger qualifies this cycle. That same edge clears commitPending and drives cfgApplied=1 for one cycle.
  - A commit during HOLD or during shifting is deferred, never dropped. Multiple requests collapse into one.
- Forward permutation (combinational):
  - qInt[i] = qIn[sel[i]]; qInt[i] = 0 if sel[i] >= W.
- Override (combinational on registered state):
  - qOvr = overrideActive ? (qInt & ~mask[a]) | (value[a] & mask[a]) : qInt, where a = activeIdx.
- Inverse permutation (combinational, qIn->qOut latency 0):
  - qOut[j] = qOvr[i] for the lowest i with sel[i]==j.
  - If no i maps to j, qOut[j] = qIn[j] (passthrough).
- Trigger qualification:
  - trigger[k]=1 and hold[k]!=0. A record with hold=0 is disabled.
- FSM IDLE:
  - If any trigger qualifies, take lowest k: activeIdx<=k, cnt<=hold[k], state<=HOLD, overrideActive<=1.
  - A trigger sampled at edge t is applied to qOut from t+1 for exactly hold[k] cycles.
- FSM HOLD:
  - A qualifying k < activeIdx preempts: activeIdx<=k, cnt<=hold[k].
  - A qualifying k == activeIdx reloads cnt<=hold[k] (extend).
  - k > activeIdx is ignored.
  - Otherwise, if cnt==1: state<=IDLE, overrideActive<=0, activeIdx<=0; else cnt<=cnt-1.
- Simultaneous triggers: lowest index wins. A preempt or extend in the cycle cnt==1 takes precedence over the exit.
- The active config is stable throughout HOLD, because commit only happens in IDLE.
- rst asserted mid-HOLD or mid-shift: immediate return to reset state; a partial shadow is discarded.

Test Plan:
- Reset, no config; drive qIn=38'h2A_5555_AAAA -> qOut identical, overrideActive=0, activeIdx=0.
- Shift a config with sel swapping bits 0 and 37 (rest identity); commit.
  - cfgApplied pulses once.
  - qIn=1 gives qOut=1 (round-trip restores position).
  - sel[5]=40 (invalid, all other sel identity) gives qOut[5]=qIn[5] (unmapped passthrough).
- Record 2: mask=0xFF, value=0x5A, hold=3; pulse trigger[2] at edge t.
  - overrideActive=1 for cycles t+1..t+3.
  - qOut[7:0]=0x5A with other bits = qIn; passthrough from t+4.
- Record 2 active, hold=3:
  - Assert trigger[0] (hold=2) at cnt=2 -> activeIdx=0 next cycle, 2 more override cycles.
  - trigger[3] asserted mid-hold -> no effect.
  - Re-pulse trigger[2] at cnt=1 -> 3 further cycles.
- Pulse cfgCommit during HOLD -> no cfgApplied until the cycle after the return to IDLE; the new config takes effect only then. Record with hold=0 triggered -> overrideActive stays 0.
- Assert rst mid-HOLD and mid-shift -> qOut=qIn immediately, overrideActive=0, a prior pending commit is cleared, and committing without reshifting loads an all-zero shadow (sel all 0).
